hdr_lsu_multi: RTL
==================

Name: hdr_lsu_multi

Overview:
- Parametrised successor of the allocator's single-header load/store unit, between allocator core and memory port.
- Moves a header of NUM_FIELDS words, selected per request by a field mask. Supported operations: LOAD, STORE, LOCK (poll plus CAS with bounded retry) and UNLOCK.
- Exactly one memory transaction outstanding at a time. Unmasked fields are never touched.
- Replaces fixed size/next_addr sequencing with a field-index counter. Adds an error response for lock timeout.

Parameters:
- DATA_W, 64: memory word and header field width.
- ADDR_W, 64: address width.
- NUM_FIELDS, 4: header words per block; must be at least 1.
- FIELD_STRIDE, 8: byte distance between consecutive header fields.
- LOCK_OFFSET, 0: byte offset of the lock word from the block base.
- EMPTY_KEY, 0: value of the lock word when it is free.
- LOCK_ID, 1: value written by a successful CAS; must differ from EMPTY_KEY.
- MAX_RETRY, 16: lock attempts (poll or CAS) before an error is reported; must be at least 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- core_req_val_i  in  1  core request valid.
- core_req_rdy_o  out  1  LSU accepts a request.
- core_req_op_i  in  2  operation: LOAD=0, STORE=1, LOCK=2, UNLOCK=3.
- core_req_addr_i  in  ADDR_W  block base address.
- core_req_mask_i  in  NUM_FIELDS  field select; bit i selects field i.
- core_req_data_i  in  NUM_FIELDS*DATA_W  store data; field i is in slice i.
- core_rsp_val_o  out  1  response valid.
- core_rsp_rdy_i  in  1  core accepts the response.
- core_rsp_addr_o  out  ADDR_W  echoed base address.
- core_rsp_data_o  out  NUM_FIELDS*DATA_W  loaded fields; unloaded slices are 0.
- core_rsp_err_o  out  1  lock retry count exhausted.
- mem_req_val_o  out  1  memory request valid.
- mem_req_rdy_i  in  1  memory accepts the request.
- mem_req_is_write_o  out  1  1 = write, 0 = read.
- mem_req_is_cas_o  out  1  1 = compare-and-swap.
- mem_req_addr_o  out  ADDR_W  memory address.
- mem_req_data_o  out  DATA_W  write data, or CAS new value.
- mem_req_cas_exp_o  out  DATA_W  CAS expected value.
- mem_rsp_val_i  in  1  memory response valid.
- mem_rsp_rdy_o  out  1  LSU accepts the response.
- mem_rsp_data_i  in  DATA_W  read data, or CAS old value.

Behaviour:
- Reset (async assert, sync deassert):
  - State goes to IDLE; all registers clear.
  - All outputs are 0 except core_req_rdy_o=1.
  - Reset mid-operation abandons the transaction; the bench must drop any in-flight memory response.
- All outputs come from registered state; the mem_req_* and core_rsp_* buses hold stable while val=1 and rdy=0.
- IDLE:
  - core_req_rdy_o=1. On val&rdy, latch op, addr, mask and data; clear the rsp data register, retry counter and err.
  - LOAD/STORE with mask=0: go straight to RESP, with no memory traffic.
  - Otherwise go to SCAN with field index idx = lowest set mask bit, or to LOCK_POLL, or to UNLOCK_REQ.
- SCAN, for LOAD/STORE:
  - Drive mem_req_val_o=1 with addr = base + idx*FIELD_STRIDE, computed modulo 2^ADDR_W.
  - is_write = (op==STORE); data = slice idx.
  - On mem_req_rdy_i, go to SCAN_WAIT.
- SCAN_WAIT:
  - mem_rsp_rdy_o=1. On mem_rsp_val_i, a LOAD writes rsp slice idx.
  - Advance idx to the next set mask bit, or go to RESP after the highest set bit.
- LOCK_POLL:
  - Read base + LOCK_OFFSET, then go to LOCK_POLL_WAIT.
  - If the returned data equals EMPTY_KEY, go to LOCK_CAS.
  - Otherwise increment retry and return to LOCK_POLL.
- LOCK_CAS:
  - is_cas=1, is_write=0, cas_exp=EMPTY_KEY, data=LOCK_ID, same address. Then go to LOCK_CAS_WAIT.
  - Old value == EMPTY_KEY: success, go to RESP.
  - Otherwise increment retry and go to LOCK_POLL.
- Retry limit: when the incremented retry equals MAX_RETRY, set err=1 and go to RESP.
  - The counter is a $clog2(MAX_RETRY+1)-bit saturating counter.
- UNLOCK_REQ: write EMPTY_KEY to base + LOCK_OFFSET. UNLOCK_WAIT consumes the write ack, then goes to RESP.
- RESP:
  - core_rsp_val_o=1 with latched addr, data and err.
  - On core_rsp_rdy_i, go to IDLE; the next request can be accepted one cycle later.
- Handshake timing:
  - mem_rsp_rdy_o=1 only in *_WAIT states. A response arriving in the same cycle as the request handshake is not accepted until the next cycle.
  - Back-to-back: the memory request is issued the cycle after the core handshake, so minimum LOAD latency with one field is 3 cycles to core_rsp_val_o.

Decomposition:
- allocator_pkg gains:
  - lsu_op_e, extended with UNLOCK.
  - A parametrised field-index helper function.
  - Constants for the default EMPTY_KEY and LOCK_ID.
- One sub-module, hdr_lsu_mask_scan: combinational "next set bit at or after idx" over NUM_FIELDS, returning a found flag and the index.

Test Plan:
- Reset: assert rst_ni=0 mid-SCAN -> all outputs 0 except core_req_rdy_o=1; a clean LOAD afterwards succeeds.
- LOAD: base=0x1000, mask=4'b1010, memory returns 0xAA then 0xBB:
  - Reads go to 0x1008 then 0x1018.
  - Response data is slice1=0xAA, slice3=0xBB, others 0; err=0.
- STORE, with mem_req_rdy_i held low 3 cycles per request: mask=4'b0001, data 0x55 -> one write to base with data 0x55; request buses stay stable while stalled.
- LOCK: lock word returns 0x7, 0x7, then EMPTY_KEY:
  - Three polls are issued, then a CAS with exp=0, new=1, which returns 0.
  - Response has err=0.
- LOCK timeout: MAX_RETRY=4, lock word always 0x7 -> exactly 4 polls, then response with err=1.
  - Second case: CAS old value returns 0x9 -> repoll.
- UNLOCK, plus LOAD with mask=0:
  - UNLOCK writes EMPTY_KEY to base+LOCK_OFFSET.
  - mask=0 gives a response with zero memory requests.
  - core_rsp_rdy_i held low 5 cycles -> response held stable throughout.

Source files
------------

// File: rtl/allocator_pkg.sv
// Shared types and constants for the allocator's header load/store unit.
// Holds the operation/state encodings, lock-word defaults and the field address helper.
package allocator_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_STORE  = 2'd1,
    OP_LOCK   = 2'd2,
    OP_UNLOCK = 2'd3
  } lsu_op_e;

  typedef enum logic [3:0] {
    ST_IDLE           = 4'd0,
    ST_SCAN           = 4'd1,
    ST_SCAN_WAIT      = 4'd2,
    ST_LOCK_POLL      = 4'd3,
    ST_LOCK_POLL_WAIT = 4'd4,
    ST_LOCK_CAS       = 4'd5,
    ST_LOCK_CAS_WAIT  = 4'd6,
    ST_UNLOCK_REQ     = 4'd7,
    ST_UNLOCK_WAIT    = 4'd8,
    ST_RESP           = 4'd9
  } lsu_state_e;

  localparam logic [63:0] DEFAULT_EMPTY_KEY = 64'd0;
  localparam logic [63:0] DEFAULT_LOCK_ID   = 64'd1;

  // Byte offset of header field idx from the block base.
  function automatic int unsigned field_offset(input int unsigned idx, input int unsigned stride);
    return idx * stride;
  endfunction

endpackage

// File: rtl/hdr_lsu_mask_scan.sv
// Combinational search for the lowest set mask bit at or after a start index.
// start is one bit wider than idx so "one past the last field" is representable.
module hdr_lsu_mask_scan #(
  parameter int NUM_FIELDS = 4,
  parameter int IDX_W      = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic [NUM_FIELDS-1:0] mask,
  input  logic [IDX_W:0]        start,
  output logic                  found,
  output logic [IDX_W-1:0]      idx
);

  // Walking downward lets the lowest qualifying bit win.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(start))) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/hdr_lsu_multi.sv
// Multi-field header load/store unit with lock/unlock; one memory transaction in flight.
// Handshakes: a transfer happens on the rising clock edge where val and rdy are both 1; val-side buses hold while rdy is 0.
module hdr_lsu_multi
  import allocator_pkg::*;
#(
  parameter int unsigned      DATA_W       = 64,
  parameter int unsigned      ADDR_W       = 64,
  parameter int unsigned      NUM_FIELDS   = 4,
  parameter int unsigned      FIELD_STRIDE = 8,
  parameter int unsigned      LOCK_OFFSET  = 0,
  parameter logic [DATA_W-1:0] EMPTY_KEY   = DATA_W'(DEFAULT_EMPTY_KEY),
  parameter logic [DATA_W-1:0] LOCK_ID     = DATA_W'(DEFAULT_LOCK_ID),
  parameter int unsigned      MAX_RETRY    = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         core_req_val_i,
  output logic                         core_req_rdy_o,
  input  logic [1:0]                   core_req_op_i,
  input  logic [ADDR_W-1:0]            core_req_addr_i,
  input  logic [NUM_FIELDS-1:0]        core_req_mask_i,
  input  logic [NUM_FIELDS*DATA_W-1:0] core_req_data_i,
  output logic                         core_rsp_val_o,
  input  logic                         core_rsp_rdy_i,
  output logic [ADDR_W-1:0]            core_rsp_addr_o,
  output logic [NUM_FIELDS*DATA_W-1:0] core_rsp_data_o,
  output logic                         core_rsp_err_o,
  output logic                         mem_req_val_o,
  input  logic                         mem_req_rdy_i,
  output logic                         mem_req_is_write_o,
  output logic                         mem_req_is_cas_o,
  output logic [ADDR_W-1:0]            mem_req_addr_o,
  output logic [DATA_W-1:0]            mem_req_data_o,
  output logic [DATA_W-1:0]            mem_req_cas_exp_o,
  input  logic                         mem_rsp_val_i,
  output logic                         mem_rsp_rdy_o,
  input  logic [DATA_W-1:0]            mem_rsp_data_i,
  output logic [3:0]                   dbg_state_o
);

  localparam int IDX_W   = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int DW      = NUM_FIELDS * DATA_W;

  lsu_state_e             state_q;
  lsu_op_e                op_q;
  logic [ADDR_W-1:0]      base_q;
  logic [NUM_FIELDS-1:0]  mask_q;
  logic [DW-1:0]          wdata_q;
  logic [DW-1:0]          rdata_q;
  logic [IDX_W-1:0]       idx_q;
  logic [RETRY_W-1:0]     retry_q;
  logic                   err_q;
  logic                   req_rdy_q;
  logic                   rsp_val_q;
  logic                   mreq_val_q;
  logic                   mreq_wr_q;
  logic                   mreq_cas_q;
  logic [ADDR_W-1:0]      mreq_addr_q;
  logic [DATA_W-1:0]      mreq_data_q;
  logic [DATA_W-1:0]      mreq_exp_q;
  logic                   mrsp_rdy_q;

  logic [NUM_FIELDS-1:0]  scan_mask;
  logic [IDX_W:0]         scan_start;
  logic                   scan_found;
  logic [IDX_W-1:0]       scan_idx;
  logic [ADDR_W-1:0]      cur_base;
  logic [DW-1:0]          cur_wdata;
  logic [ADDR_W-1:0]      scan_addr;
  logic [DATA_W-1:0]      scan_wdata;
  logic [ADDR_W-1:0]      lock_addr;
  logic [RETRY_W-1:0]     retry_inc;
  logic                   retry_done;
  logic                   cur_is_store;

  // In IDLE the scanner looks at the incoming request; afterwards it finds the next field past idx.
  always_comb begin
    if (state_q == ST_IDLE) begin
      scan_mask    = core_req_mask_i;
      scan_start   = '0;
      cur_base     = core_req_addr_i;
      cur_wdata    = core_req_data_i;
      cur_is_store = (core_req_op_i == OP_STORE);
    end else begin
      scan_mask    = mask_q;
      scan_start   = {1'b0, idx_q} + (IDX_W + 1)'(1);
      cur_base     = base_q;
      cur_wdata    = wdata_q;
      cur_is_store = (op_q == OP_STORE);
    end
  end

  hdr_lsu_mask_scan #(
    .NUM_FIELDS (NUM_FIELDS),
    .IDX_W      (IDX_W)
  ) u_scan (
    .mask  (scan_mask),
    .start (scan_start),
    .found (scan_found),
    .idx   (scan_idx)
  );

  assign scan_addr  = cur_base + ADDR_W'(field_offset(32'(scan_idx), FIELD_STRIDE));
  assign scan_wdata = cur_wdata[scan_idx*DATA_W +: DATA_W];
  assign lock_addr  = cur_base + ADDR_W'(LOCK_OFFSET);
  assign retry_inc  = (retry_q == RETRY_W'(MAX_RETRY)) ? retry_q : retry_q + RETRY_W'(1);
  assign retry_done = (retry_inc == RETRY_W'(MAX_RETRY));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LOAD;
      base_q      <= '0;
      mask_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      idx_q       <= '0;
      retry_q     <= '0;
      err_q       <= 1'b0;
      req_rdy_q   <= 1'b1;
      rsp_val_q   <= 1'b0;
      mreq_val_q  <= 1'b0;
      mreq_wr_q   <= 1'b0;
      mreq_cas_q  <= 1'b0;
      mreq_addr_q <= '0;
      mreq_data_q <= '0;
      mreq_exp_q  <= '0;
      mrsp_rdy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (core_req_val_i) begin
            op_q      <= lsu_op_e'(core_req_op_i);
            base_q    <= core_req_addr_i;
            mask_q    <= core_req_mask_i;
            wdata_q   <= core_req_data_i;
            rdata_q   <= '0;
            retry_q   <= '0;
            err_q     <= 1'b0;
            req_rdy_q <= 1'b0;
            case (lsu_op_e'(core_req_op_i))
              OP_LOAD, OP_STORE: begin
                if (core_req_mask_i == '0) begin
                  state_q   <= ST_RESP;
                  rsp_val_q <= 1'b1;
                end else begin
                  state_q     <= ST_SCAN;
                  idx_q       <= scan_idx;
                  mreq_val_q  <= 1'b1;
                  mreq_wr_q   <= cur_is_store;
                  mreq_cas_q  <= 1'b0;
                  mreq_addr_q <= scan_addr;
                  mreq_data_q <= scan_wdata;
                  mreq_exp_q  <= '0;
                end
              end
              OP_LOCK: begin
                state_q     <= ST_LOCK_POLL;
                mreq_val_q  <= 1'b1;
                mreq_wr_q   <= 1'b0;
                mreq_cas_q  <= 1'b0;
                mreq_addr_q <= lock_addr;
                mreq_data_q <= '0;
                mreq_exp_q  <= '0;
              end
              default: begin
                state_q     <= ST_UNLOCK_REQ;
                mreq_val_q  <= 1'b1;
                mreq_wr_q   <= 1'b1;
                mreq_cas_q  <= 1'b0;
                mreq_addr_q <= lock_addr;
                mreq_data_q <= EMPTY_KEY;
                mreq_exp_q  <= '0;
              end
            endcase
          end
        end
        ST_SCAN, ST_LOCK_POLL, ST_LOCK_CAS, ST_UNLOCK_REQ: begin
          if (mem_req_rdy_i) begin
            mreq_val_q <= 1'b0;
            mrsp_rdy_q <= 1'b1;
            case (state_q)
              ST_SCAN:      state_q <= ST_SCAN_WAIT;
              ST_LOCK_POLL: state_q <= ST_LOCK_POLL_WAIT;
              ST_LOCK_CAS:  state_q <= ST_LOCK_CAS_WAIT;
              default:      state_q <= ST_UNLOCK_WAIT;
            endcase
          end
        end
        ST_SCAN_WAIT: begin
          if (mem_rsp_val_i) begin
            mrsp_rdy_q <= 1'b0;
            if (op_q == OP_LOAD) rdata_q[idx_q*DATA_W +: DATA_W] <= mem_rsp_data_i;
            if (scan_found) begin
              state_q     <= ST_SCAN;
              idx_q       <= scan_idx;
              mreq_val_q  <= 1'b1;
              mreq_addr_q <= scan_addr;
              mreq_data_q <= scan_wdata;
            end else begin
              state_q   <= ST_RESP;
              rsp_val_q <= 1'b1;
            end
          end
        end
        ST_LOCK_POLL_WAIT, ST_LOCK_CAS_WAIT: begin
          if (mem_rsp_val_i) begin
            mrsp_rdy_q <= 1'b0;
            if (mem_rsp_data_i == EMPTY_KEY) begin
              if (state_q == ST_LOCK_POLL_WAIT) begin
                // Lock looked free: try to claim it atomically.
                state_q     <= ST_LOCK_CAS;
                mreq_val_q  <= 1'b1;
                mreq_wr_q   <= 1'b0;
                mreq_cas_q  <= 1'b1;
                mreq_data_q <= LOCK_ID;
                mreq_exp_q  <= EMPTY_KEY;
              end else begin
                state_q   <= ST_RESP;
                rsp_val_q <= 1'b1;
              end
            end else begin
              retry_q <= retry_inc;
              if (retry_done) begin
                err_q     <= 1'b1;
                state_q   <= ST_RESP;
                rsp_val_q <= 1'b1;
              end else begin
                state_q     <= ST_LOCK_POLL;
                mreq_val_q  <= 1'b1;
                mreq_wr_q   <= 1'b0;
                mreq_cas_q  <= 1'b0;
                mreq_data_q <= '0;
                mreq_exp_q  <= '0;
              end
            end
          end
        end
        ST_UNLOCK_WAIT: begin
          if (mem_rsp_val_i) begin
            mrsp_rdy_q <= 1'b0;
            state_q    <= ST_RESP;
            rsp_val_q  <= 1'b1;
          end
        end
        ST_RESP: begin
          if (core_rsp_rdy_i) begin
            rsp_val_q <= 1'b0;
            req_rdy_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          req_rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign core_req_rdy_o     = req_rdy_q;
  assign core_rsp_val_o     = rsp_val_q;
  assign core_rsp_addr_o    = base_q;
  assign core_rsp_data_o    = rdata_q;
  assign core_rsp_err_o     = err_q;
  assign mem_req_val_o      = mreq_val_q;
  assign mem_req_is_write_o = mreq_wr_q;
  assign mem_req_is_cas_o   = mreq_cas_q;
  assign mem_req_addr_o     = mreq_addr_q;
  assign mem_req_data_o     = mreq_data_q;
  assign mem_req_cas_exp_o  = mreq_exp_q;
  assign mem_rsp_rdy_o      = mrsp_rdy_q;
  assign dbg_state_o        = state_q;

endmodule
